// File: rtl/mod_sub_serial.sv
// Limb-serial modular subtractor: (a - b) mod p, one LIMB_W slice per clock.
// A subtract pass runs first; an add-back-p pass follows only when it borrows out.
module mod_sub_serial #(
  parameter int WIDTH  = 256,
  parameter int LIMB_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mod_sub_res,
  output logic             add_back
);

  localparam int NLIMB = WIDTH / LIMB_W;
  localparam int CNT_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  typedef enum logic [1:0] {IDLE, SUB, ADD, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   p_r;
  logic [CNT_W-1:0]   cnt;
  logic               flag;
  logic               last_limb;
  logic [LIMB_W:0]    sub_w;
  logic [LIMB_W:0]    add_w;

  // flag is the borrow during SUB and the carry during ADD; bit LIMB_W of each sum is its next value.
  assign last_limb = (cnt == CNT_W'(NLIMB - 1));
  assign sub_w = {1'b0, a_r[LIMB_W-1:0]} - {1'b0, b_r[LIMB_W-1:0]} - {{LIMB_W{1'b0}}, flag};
  assign add_w = {1'b0, mod_sub_res[LIMB_W-1:0]} + {1'b0, p_r[LIMB_W-1:0]} + {{LIMB_W{1'b0}}, flag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SUB;
      end
      SUB: if (last_limb) state_next = sub_w[LIMB_W] ? ADD : DONE;
      ADD: if (last_limb) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands and result are shift registers: the low limb is always the one being worked on,
  // and each new result limb enters at the top so the word is aligned after NLIMB shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= '0;
      b_r         <= '0;
      p_r         <= '0;
      cnt         <= '0;
      flag        <= 1'b0;
      mod_sub_res <= '0;
      add_back    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r      <= a;
          b_r      <= b;
          p_r      <= p;
          cnt      <= '0;
          flag     <= 1'b0;
          add_back <= 1'b0;
        end
        SUB: begin
          a_r         <= a_r >> LIMB_W;
          b_r         <= b_r >> LIMB_W;
          mod_sub_res <= {sub_w[LIMB_W-1:0], mod_sub_res[WIDTH-1:LIMB_W]};
          cnt         <= last_limb ? '0 : cnt + CNT_W'(1);
          flag        <= last_limb ? 1'b0 : sub_w[LIMB_W];
          if (last_limb) add_back <= sub_w[LIMB_W];
        end
        ADD: begin
          p_r         <= p_r >> LIMB_W;
          mod_sub_res <= {add_w[LIMB_W-1:0], mod_sub_res[WIDTH-1:LIMB_W]};
          cnt         <= last_limb ? '0 : cnt + CNT_W'(1);
          flag        <= last_limb ? 1'b0 : add_w[LIMB_W];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_sub_serial.sv
// Directed and random bench for mod_sub_serial with immediate-assertion checks.
module tb_mod_sub_serial;

  localparam logic [255:0] NIST_P = 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;
  localparam logic [255:0] SM2_P  = 256'hfffffffeffffffffffffffffffffffffffffffff00000000ffffffffffffffff;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] a;
  logic [255:0] b;
  logic [255:0] p;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] mod_sub_res;
  logic         add_back;

  int tests;
  int fails;

  mod_sub_serial dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .p           (p),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .mod_sub_res (mod_sub_res),
    .add_back    (add_back)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [255:0] rand_below(input logic [255:0] modulus);
    logic [255:0] x;
    for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
    if (x >= modulus) x = x - modulus;
    return x;
  endfunction

  // Issues one operation, checks latency, holds the result for `stall` cycles, then consumes it.
  task automatic applyStimulus(input logic [255:0] ta, input logic [255:0] tb, input logic [255:0] tp,
                               input logic [255:0] exp_res, input logic exp_ab, input int exp_lat,
                               input int stall);
    int wait_cnt;
    int lat;
    a         = ta;
    b         = tb;
    p         = tp;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    wait_cnt  = 0;
    while (!in_ready && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    checkOutput("accept_ready", {255'd0, in_ready}, 256'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    p = '0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      checkOutput("busy_in_ready", {255'd0, in_ready}, 256'd0);
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", 256'(lat), 256'(exp_lat));
    checkOutput("result", mod_sub_res, exp_res);
    checkOutput("add_back", {255'd0, add_back}, {255'd0, exp_ab});
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      checkOutput("stall_valid", {255'd0, out_valid}, 256'd1);
      checkOutput("stall_in_ready", {255'd0, in_ready}, 256'd0);
      checkOutput("stall_result", mod_sub_res, exp_res);
      checkOutput("stall_add_back", {255'd0, add_back}, {255'd0, exp_ab});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("consumed_valid", {255'd0, out_valid}, 256'd0);
    checkOutput("consumed_in_ready", {255'd0, in_ready}, 256'd1);
  endtask

  initial begin
    logic [255:0] ra;
    logic [255:0] rb;
    logic [255:0] rp;
    logic [255:0] rexp;
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    p = '0;
    #1;
    checkOutput("reset_in_ready", {255'd0, in_ready}, 256'd1);
    checkOutput("reset_out_valid", {255'd0, out_valid}, 256'd0);
    checkOutput("reset_res", mod_sub_res, 256'd0);
    checkOutput("reset_add_back", {255'd0, add_back}, 256'd0);
    #11;
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(256'hfd5cca6c33dec372012c417c5801689fa76071ec99b1d835c575e6c0dfc77957,
                  256'h16222f061fff868ca7eff679aef097c633adbf6182f3151f2c7d4e29274eb288, NIST_P,
                  256'he73a9b6613df3ce5593c4b02a910d0d973b2b28b16bec31698f89897b878c6cf, 1'b0, 4, 0);
    applyStimulus(256'd5, 256'd7, NIST_P,
                  256'hffffffff00000001000000000000000000000000fffffffffffffffffffffffd, 1'b1, 8, 0);
    applyStimulus(256'd0, SM2_P - 256'd1, SM2_P, 256'd1, 1'b1, 8, 0);
    applyStimulus(256'h1234, 256'h1234, SM2_P, 256'd0, 1'b0, 4, 0);
    applyStimulus(256'h1_0000_0000_0000_0000, 256'd1, SM2_P, 256'h0000_0000_0000_0000_ffff_ffff_ffff_ffff, 1'b0, 4, 0);
    applyStimulus(256'd3, 256'd9, SM2_P, SM2_P - 256'd6, 1'b1, 8, 10);

    // Reset while the add-back pass is running: 6 edges after accept lands in ADD.
    a        = 256'd5;
    b        = 256'd7;
    p        = NIST_P;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", {255'd0, out_valid}, 256'd0);
    checkOutput("midreset_in_ready", {255'd0, in_ready}, 256'd1);
    checkOutput("midreset_res", mod_sub_res, 256'd0);
    checkOutput("midreset_add_back", {255'd0, add_back}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(256'd10, 256'd4, NIST_P, 256'd6, 1'b0, 4, 2);

    for (int r = 0; r < 20; r++) begin
      rp   = (r < 10) ? NIST_P : SM2_P;
      ra   = rand_below(rp);
      rb   = rand_below(rp);
      rexp = (ra >= rb) ? ra - rb : ra - rb + rp;
      applyStimulus(ra, rb, rp, rexp, ra < rb, (ra < rb) ? 8 : 4, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
